// File: rtl/goto_table_writer_if.sv
// Pattern-input, goto-RAM and output-flag-RAM bundle of goto_table_writer.
// master = the writer, slave = pattern source plus the two RAMs.
interface goto_table_writer_if #(
    parameter int STATE_W = 8,
    parameter int CHAR_W  = 4
);
    logic                       PAT_VALID;
    logic [CHAR_W-1:0]          PAT_CHAR;
    logic                       PAT_LAST;
    logic                       PAT_READY;
    logic                       RD_EN;
    logic [STATE_W+CHAR_W-1:0]  RD_ADDR;
    logic [STATE_W-1:0]         RD_DATA;
    logic                       WE;
    logic [STATE_W+CHAR_W-1:0]  WR_ADDR;
    logic [STATE_W-1:0]         WR_DATA;
    logic                       OUT_WE;
    logic [STATE_W-1:0]         OUT_ADDR;
    logic                       OUT_DATA;
    logic                       BUSY;
    logic                       DONE;
    logic                       OVF;
    logic [7:0]                 PAT_COUNT;

    modport master (
        input  PAT_VALID, PAT_CHAR, PAT_LAST, RD_DATA,
        output PAT_READY, RD_EN, RD_ADDR, WE, WR_ADDR, WR_DATA,
               OUT_WE, OUT_ADDR, OUT_DATA, BUSY, DONE, OVF, PAT_COUNT
    );

    modport slave (
        output PAT_VALID, PAT_CHAR, PAT_LAST, RD_DATA,
        input  PAT_READY, RD_EN, RD_ADDR, WE, WR_ADDR, WR_DATA,
               OUT_WE, OUT_ADDR, OUT_DATA, BUSY, DONE, OVF, PAT_COUNT
    );
endinterface

// File: rtl/goto_table_writer.sv
// Aho-Corasick goto-trie builder: clears goto/flag RAMs, then inserts patterns one char per handshake.
// Optional build macro PATTERN_COUNT_EN adds a saturating inserted-pattern counter on PAT_COUNT.
module goto_table_writer #(
    parameter int STATE_W = 8,
    parameter int CHAR_W  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLEAR,
    goto_table_writer_if.master  bus
);
    localparam int ADDR_W = STATE_W + CHAR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_CLR    = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_LOOK   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [STATE_W-1:0]   r_cur;
    logic [STATE_W-1:0]   r_next_free;
    logic [ADDR_W-1:0]    r_clr_addr;
    logic                 r_ovf;
    logic [CHAR_W-1:0]    r_char;
    logic                 r_last;
    logic [7:0]           w_pat_count;

    logic                 w_hit;
    logic                 w_can_alloc;
    logic                 w_ok;
    logic [STATE_W-1:0]   w_resolved;

    // next_free of zero means the state space has wrapped and is exhausted
    assign w_hit       = (bus.RD_DATA != {STATE_W{1'b0}});
    assign w_can_alloc = (r_next_free != {STATE_W{1'b0}});
    assign w_ok        = w_hit || w_can_alloc;
    assign w_resolved  = w_hit ? bus.RD_DATA : r_next_free;

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_CLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic; CLEAR overrides any handshake in the same cycle
    always_comb begin
        w_next_state = r_state;
        if (CLEAR) begin
            w_next_state = ST_CLR;
        end else begin
            case (r_state)
                ST_CLR:    w_next_state = (r_clr_addr == LAST_ADDR) ? ST_ACCEPT : ST_CLR;
                ST_ACCEPT: w_next_state = bus.PAT_VALID ? ST_LOOK : ST_ACCEPT;
                ST_LOOK:   w_next_state = (!w_ok && !r_last) ? ST_DRAIN : ST_ACCEPT;
                ST_DRAIN:  w_next_state = (bus.PAT_VALID && bus.PAT_LAST) ? ST_ACCEPT : ST_DRAIN;
                default:   w_next_state = ST_CLR;
            endcase
        end
    end

    // trie-walk datapath: current state, allocator, sweep address, overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cur       <= {STATE_W{1'b0}};
            r_next_free <= STATE_W'(1);
            r_clr_addr  <= {ADDR_W{1'b0}};
            r_ovf       <= 1'b0;
            r_char      <= {CHAR_W{1'b0}};
            r_last      <= 1'b0;
        end else if (CLEAR) begin
            r_clr_addr  <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                ST_CLR: begin
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    if (r_clr_addr == LAST_ADDR) begin
                        r_cur       <= {STATE_W{1'b0}};
                        r_next_free <= STATE_W'(1);
                        r_ovf       <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (bus.PAT_VALID) begin
                        r_char <= bus.PAT_CHAR;
                        r_last <= bus.PAT_LAST;
                    end
                end
                ST_LOOK: begin
                    if (w_hit) begin
                        r_cur <= bus.RD_DATA;
                    end else if (w_can_alloc) begin
                        r_cur       <= r_next_free;
                        r_next_free <= r_next_free + STATE_W'(1);
                    end else begin
                        r_ovf <= 1'b1;
                    end
                    // end of pattern (inserted or failed) returns to the root
                    if (r_last) begin
                        r_cur <= {STATE_W{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    if (bus.PAT_VALID && bus.PAT_LAST) begin
                        r_cur <= {STATE_W{1'b0}};
                    end
                end
                default: begin
                    r_cur <= {STATE_W{1'b0}};
                end
            endcase
        end
    end

`ifdef PATTERN_COUNT_EN
    logic [7:0] r_pat_count;

    // saturating count of DONE pulses, zeroed for the whole sweep
    always_ff @(posedge CLK) begin
        if (RST || (r_state == ST_CLR)) begin
            r_pat_count <= 8'd0;
        end else if (bus.DONE && (r_pat_count != 8'hFF)) begin
            r_pat_count <= r_pat_count + 8'd1;
        end else begin
            r_pat_count <= r_pat_count;
        end
    end

    assign w_pat_count = r_pat_count;
`else
    assign w_pat_count = 8'd0;
`endif

    // output decode; all strobes held low while RST is asserted
    always_comb begin
        bus.PAT_READY = 1'b0;
        bus.RD_EN     = 1'b0;
        bus.RD_ADDR   = {ADDR_W{1'b0}};
        bus.WE        = 1'b0;
        bus.WR_ADDR   = {ADDR_W{1'b0}};
        bus.WR_DATA   = {STATE_W{1'b0}};
        bus.OUT_WE    = 1'b0;
        bus.OUT_ADDR  = {STATE_W{1'b0}};
        bus.OUT_DATA  = 1'b0;
        bus.BUSY      = 1'b0;
        bus.DONE      = 1'b0;
        if (RST) begin
            bus.BUSY = 1'b1;
        end else begin
            case (r_state)
                ST_CLR: begin
                    bus.BUSY    = 1'b1;
                    bus.WE      = 1'b1;
                    bus.WR_ADDR = r_clr_addr;
                    if (r_clr_addr[ADDR_W-1:STATE_W] == {CHAR_W{1'b0}}) begin
                        bus.OUT_WE   = 1'b1;
                        bus.OUT_ADDR = r_clr_addr[STATE_W-1:0];
                    end else begin
                        bus.OUT_WE   = 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    bus.PAT_READY = 1'b1;
                    bus.RD_EN     = bus.PAT_VALID;
                    bus.RD_ADDR   = {r_cur, bus.PAT_CHAR};
                end
                ST_LOOK: begin
                    if (!w_hit && w_can_alloc) begin
                        bus.WE      = 1'b1;
                        bus.WR_ADDR = {r_cur, r_char};
                        bus.WR_DATA = r_next_free;
                    end else begin
                        bus.WE      = 1'b0;
                    end
                    if (w_ok && r_last) begin
                        bus.OUT_WE   = 1'b1;
                        bus.OUT_ADDR = w_resolved;
                        bus.OUT_DATA = 1'b1;
                        bus.DONE     = 1'b1;
                    end else begin
                        bus.DONE     = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    bus.PAT_READY = 1'b1;
                end
                default: begin
                    bus.BUSY = 1'b1;
                end
            endcase
        end
    end

    assign bus.OVF       = r_ovf;
    assign bus.PAT_COUNT = w_pat_count;
endmodule

// File: tb/tb_goto_table_writer.sv
// Randomized bench for goto_table_writer against a map-based trie model with behavioural RAMs.
module tb_goto_table_writer;
    logic CLK = 1'b0;
    logic RST;
    logic CLEAR;
    int   total = 0;
    int   bad   = 0;

    goto_table_writer_if bus ();

    goto_table_writer dut (
        .CLK   (CLK),
        .RST   (RST),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // behavioural goto RAM (1-cycle read) and flag RAM
    logic [7:0] gmem [0:4095];
    logic       fmem [0:255];
    logic [7:0] rd_data_r = 8'd0;
    assign bus.RD_DATA = rd_data_r;

    always @(posedge CLK) begin
        if (bus.WE === 1'b1)     gmem[bus.WR_ADDR] <= bus.WR_DATA;
        if (bus.RD_EN === 1'b1)  rd_data_r <= gmem[bus.RD_ADDR];
        if (bus.OUT_WE === 1'b1) fmem[bus.OUT_ADDR] <= bus.OUT_DATA;
    end

    // monitor of insertion-time activity (outside the sweep)
    logic [19:0] wr_q [$];
    logic [7:0]  out_q [$];
    int          done_cnt = 0;
    int          done_out_err = 0;
    always @(negedge CLK) begin
        if (RST === 1'b0 && bus.BUSY === 1'b0) begin
            if (bus.WE === 1'b1)     wr_q.push_back({bus.WR_ADDR, bus.WR_DATA});
            if (bus.OUT_WE === 1'b1) out_q.push_back(bus.OUT_ADDR);
            if (bus.DONE === 1'b1)   done_cnt++;
            if (bus.DONE !== bus.OUT_WE) done_out_err++;
        end
    end

    // reference model: trie as a map from (state*16+char) to child state
    int  trie [int];
    int  m_nf;
    bit  m_ovf;
    int  m_cnt;
    logic [3:0] pat_q [$];
    bit  clr_seen [0:4095];
    bit  out_seen [0:255];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        trie.delete();
        m_nf  = 1;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // called at a negedge; samples every cycle until PAT_READY rises
    task automatic sweep_check(input string tag);
        int n = 0;
        int busy_n = 0;
        int seen_n = 0;
        int oseen_n = 0;
        logic [11:0] first_addr = 12'hFFF;
        foreach (clr_seen[i]) clr_seen[i] = 1'b0;
        foreach (out_seen[i]) out_seen[i] = 1'b0;
        while (bus.PAT_READY !== 1'b1 && n < 5000) begin
            if (n == 0) first_addr = bus.WR_ADDR;
            if (bus.BUSY === 1'b1) busy_n++;
            if (bus.WE === 1'b1 && bus.WR_DATA === 8'd0 && !clr_seen[bus.WR_ADDR]) begin
                clr_seen[bus.WR_ADDR] = 1'b1;
                seen_n++;
            end
            if (bus.OUT_WE === 1'b1 && bus.OUT_DATA === 1'b0 && !out_seen[bus.OUT_ADDR]) begin
                out_seen[bus.OUT_ADDR] = 1'b1;
                oseen_n++;
            end
            n++;
            @(negedge CLK);
        end
        check_eq({tag, "_cycles"}, 32'(n), 32'd4096);
        check_eq({tag, "_busy"}, 32'(busy_n), 32'd4096);
        check_eq({tag, "_goto_cleared"}, 32'(seen_n), 32'd4096);
        check_eq({tag, "_flag_cleared"}, 32'(oseen_n), 32'd256);
        check_eq({tag, "_first_addr"}, 32'(first_addr), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(bus.BUSY), 32'd0);
        check_eq({tag, "_ovf"}, 32'(bus.OVF), 32'd0);
        check_eq({tag, "_count"}, 32'(bus.PAT_COUNT), 32'd0);
    endtask

    task automatic send_char(input logic [3:0] c, input logic last);
        int guard = 0;
        bus.PAT_VALID = 1'b1;
        bus.PAT_CHAR  = c;
        bus.PAT_LAST  = last;
        while (bus.PAT_READY !== 1'b1 && guard < 64) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 64) check_eq("ready_timeout", 32'(guard), 32'd0);
        @(negedge CLK);
        bus.PAT_VALID = 1'b0;
        bus.PAT_LAST  = 1'b0;
    endtask

    // insert pat_q, predicting writes, flag, DONE, OVF and count from the model
    task automatic insert_pat(input string tag);
        int cur = 0;
        bit failed = 1'b0;
        int key;
        logic [19:0] exp_w [$];
        int wbase = wr_q.size();
        int obase = out_q.size();
        int dbase = done_cnt;
        int exp_count;
        foreach (pat_q[i]) begin
            if (!failed) begin
                key = cur * 16 + int'(pat_q[i]);
                if (trie.exists(key)) begin
                    cur = trie[key];
                end else if (m_nf != 0) begin
                    trie[key] = m_nf;
                    exp_w.push_back({12'(key), 8'(m_nf)});
                    cur  = m_nf;
                    m_nf = (m_nf + 1) % 256;
                end else begin
                    m_ovf  = 1'b1;
                    failed = 1'b1;
                end
            end
        end
        if (!failed && m_cnt < 255) m_cnt++;
        foreach (pat_q[i]) send_char(pat_q[i], (i == pat_q.size() - 1));
        repeat (2) @(negedge CLK);
        check_eq({tag, "_nwr"}, 32'(wr_q.size() - wbase), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && wbase + i < wr_q.size(); i++)
            check_eq({tag, "_wr"}, 32'(wr_q[wbase + i]), 32'(exp_w[i]));
        check_eq({tag, "_nflag"}, 32'(out_q.size() - obase), failed ? 32'd0 : 32'd1);
        if (!failed && out_q.size() > obase)
            check_eq({tag, "_flag_addr"}, 32'(out_q[obase]), 32'(cur));
        check_eq({tag, "_done"}, 32'(done_cnt - dbase), failed ? 32'd0 : 32'd1);
        check_eq({tag, "_ovf"}, 32'(bus.OVF), 32'(m_ovf));
`ifdef PATTERN_COUNT_EN
        exp_count = m_cnt;
`else
        exp_count = 0;
`endif
        check_eq({tag, "_count"}, 32'(bus.PAT_COUNT), 32'(exp_count));
    endtask

    initial begin
        int guard_p;
        int cur;
        int found;
        int wbase;
        int dbase;
        RST           = 1'b1;
        CLEAR         = 1'b0;
        bus.PAT_VALID = 1'b0;
        bus.PAT_CHAR  = 4'd0;
        bus.PAT_LAST  = 1'b0;

        @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_busy", 32'(bus.BUSY), 32'd1);
        check_eq("rst_ready", 32'(bus.PAT_READY), 32'd0);
        check_eq("rst_we", 32'(bus.WE), 32'd0);
        check_eq("rst_out_we", 32'(bus.OUT_WE), 32'd0);
        check_eq("rst_done", 32'(bus.DONE), 32'd0);
        check_eq("rst_ovf", 32'(bus.OVF), 32'd0);
        check_eq("rst_count", 32'(bus.PAT_COUNT), 32'd0);
        check_eq("rst_wr_addr", 32'(bus.WR_ADDR), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        sweep_check("rst_sweep");
        model_clear();

        pat_q = '{4'd1, 4'd2, 4'd3};
        insert_pat("p123");
        check_eq("p123_flag_ram", 32'(fmem[3]), 32'd1);
        pat_q = '{4'd1, 4'd2, 4'd5};
        insert_pat("p125");
        check_eq("p125_new_edge", 32'(wr_q[wr_q.size() - 1]), {12'd0, 12'h025, 8'd4});
        check_eq("p125_flag_ram", 32'(fmem[4]), 32'd1);
        pat_q = '{4'd1, 4'd2, 4'd3};
        insert_pat("p123_again");

        // random patterns until every state number is used
        guard_p = 0;
        while (m_nf != 0 && guard_p < 3000) begin
            pat_q = {};
            repeat ($urandom_range(1, 3)) pat_q.push_back(4'($urandom_range(0, 15)));
            insert_pat("rnd");
            guard_p++;
        end
        check_eq("exhaust_reached", 32'(m_nf), 32'd0);

        // walk to a state with a missing edge, then add two drained chars
        pat_q = {};
        cur = 0;
        found = -1;
        for (int d = 0; d < 300 && found < 0; d++) begin
            for (int c = 0; c < 16; c++)
                if (found < 0 && !trie.exists(cur * 16 + c)) found = c;
            if (found < 0) begin
                pat_q.push_back(4'd0);
                cur = trie[cur * 16];
            end
        end
        pat_q.push_back(4'(found));
        pat_q.push_back(4'($urandom_range(0, 15)));
        pat_q.push_back(4'($urandom_range(0, 15)));
        dbase = done_cnt;
        insert_pat("ovf_pat");
        check_eq("ovf_flag", 32'(bus.OVF), 32'd1);
        check_eq("ovf_no_done", 32'(done_cnt - dbase), 32'd0);
        pat_q = '{4'd1, 4'd2, 4'd5};
        insert_pat("existing_after_ovf");

        // CLEAR while the writer is in LOOK
        send_char(4'd7, 1'b0);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        sweep_check("clr_sweep");
        model_clear();
        wbase = wr_q.size();
        pat_q = '{4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        insert_pat("after_clr");
        check_eq("after_clr_first_state", 32'(wr_q[wbase][7:0]), 32'd1);
        for (int p = 0; p < 3; p++) begin
            pat_q = {};
            repeat ($urandom_range(1, 4)) pat_q.push_back(4'($urandom_range(0, 15)));
            insert_pat("post_clr_rnd");
        end

        check_eq("done_with_out_we", 32'(done_out_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/goto_table_writer.md
# goto_table_writer

Builds the Aho-Corasick goto trie by writing pattern characters into the goto RAM and final-state flags into the output-flag RAM. It is the write side of the table that the matcher's table reader walks at run time. It also clears both memories on reset or on request. Patterns arrive one 4-bit character per handshake. Each new edge is allocated the next free state number.

## Interface
- STATE_W, 8, state-number width; goto RAM data width
- CHAR_W, 4, character width; goto RAM address is {state, char}, STATE_W+CHAR_W bits
- CLK  in  1  clock; all logic rising-edge
- RST  in  1  synchronous, active-high reset
- CLEAR  in  1  synchronous request to restart the clear sweep; honoured in any state
- PAT_VALID  in  1  pattern character valid
- PAT_CHAR  in  4  pattern character
- PAT_LAST  in  1  the character is the last one of its pattern
- PAT_READY  out  1  writer accepts a character this cycle
- RD_EN  out  1  goto RAM read strobe
- RD_ADDR  out  12  goto RAM read address
- RD_DATA  in  8  goto RAM read data, valid 1 cycle after RD_EN
- WE  out  1  goto RAM write enable
- WR_ADDR  out  12  goto RAM write address
- WR_DATA  out  8  goto RAM write data
- OUT_WE  out  1  output-flag RAM write enable
- OUT_ADDR  out  8  output-flag RAM address (state number)
- OUT_DATA  out  1  output-flag value
- BUSY  out  1  clear sweep in progress
- DONE  out  1  one-cycle pulse when a pattern has been fully inserted
- OVF  out  1  sticky flag: state space exhausted
- PAT_COUNT  out  8  count of inserted patterns (see Configuration)

## Operation
- Goto RAM encoding: entry value 0 means "no edge". State 0 is the root and is never an edge target.
- Registers:
  - cur (current state), reset value 0.
  - next_free, reset value 1.
  - clr_addr, 12 bits.
  - OVF, reset value 0.
- States: CLR, ACCEPT, LOOK, DRAIN.
- CLR:
  - Entered on RST or CLEAR.
  - Each cycle: WE=1, WR_ADDR=clr_addr, WR_DATA=0.
  - While clr_addr<256, also OUT_WE=1, OUT_ADDR=clr_addr[7:0], OUT_DATA=0.
  - clr_addr increments by 1. After address 4095 the writer loads cur=0, next_free=1, OVF=0 and goes to ACCEPT.
  - BUSY=1 and PAT_READY=0 throughout.
- ACCEPT:
  - PAT_READY=1. RD_EN and RD_ADDR are combinational from the handshake: RD_EN=PAT_VALID, RD_ADDR={cur, PAT_CHAR}.
  - On PAT_VALID&PAT_READY: capture the character and PAT_LAST, then go to LOOK.
- LOOK:
  - RD_DATA is valid in this state.
  - If RD_DATA!=0: cur<=RD_DATA.
  - Else, if next_free!=0:
    - Write the new edge: WE=1, WR_ADDR={cur, char}, WR_DATA=next_free.
    - cur<=next_free, next_free<=next_free+1. This wraps 255→0, and 0 marks exhaustion.
  - Else: set OVF and skip the write.
    - Without last: go to DRAIN.
    - With last: DONE is not pulsed, cur<=0, go to ACCEPT.
  - On successful last: OUT_WE=1, OUT_ADDR=resolved state (RD_DATA or the newly allocated state), OUT_DATA=1. DONE=1, cur<=0.
  - Next state is ACCEPT unless DRAIN was selected.
- DRAIN:
  - PAT_READY=1. Characters are consumed with no RAM access, until PAT_LAST.
  - Then cur<=0 and go to ACCEPT.
- Once OVF is set, later patterns still insert if they need no new state (every edge already exists). Any allocation attempt fails as described above.
- A pattern whose end state is already flagged is rewritten with flag 1. It is not an error.
- CLEAR during LOOK or DRAIN aborts the pattern. Partially written edges are wiped by the sweep.

## Timing
- Reset values of outputs: PAT_READY=0, RD_EN=0, WE=0, OUT_WE=0, DONE=0, OVF=0, PAT_COUNT=0, BUSY=1. All addresses and data are 0.
- After RST deasserts, the sweep takes 4096 cycles. PAT_READY first rises on cycle 4096, counting the first post-reset cycle as cycle 0.
- Throughput: 2 cycles per character, since PAT_READY is low during LOOK. In DRAIN, 1 cycle per character.
- Goto and flag writes happen in the LOOK cycle. A write from LOOK is visible to a read issued in the following ACCEPT cycle; the RAM must be write-first or use separate cycles, and this schedule satisfies that.
- DONE is asserted in the same cycle as OUT_WE.
- Simultaneous CLEAR and a handshake: CLEAR wins and the character is dropped.

## Configuration
- PATTERN_COUNT_EN defined:
  - PAT_COUNT increments by 1 on each DONE, saturating at 255.
  - It clears on RST and in CLR.
- Undefined: PAT_COUNT is tied to 0 and the counter is not built.

## Test plan
- Reset: hold RST 2 cycles, then release. Require BUSY=1 for 4096 cycles, a WE on every address 0..4095 with WR_DATA=0, and OUT_WE on 0..255. Then PAT_READY=1.
- Insert "1,2,3", last on 3. Require writes {0,1}→1, {1,2}→2, {2,3}→3, OUT_WE addr 3 data 1, DONE=1, PAT_COUNT=1.
- Then insert "1,2,5". Require no writes for 1 and 2 (RD_DATA 1 then 2), write {2,5}→4, flag addr 4, next_free=5.
- Exhaustion: insert 255 single-edge patterns to allocate states 1..255, then insert a pattern needing a new state. Require OVF=1, no WE, DRAIN consumed through last, and no DONE.
- Assert CLEAR mid-pattern in LOOK. Require the sweep to restart at address 0, OVF=0, and the next pattern to allocate state 1.
- With PATTERN_COUNT_EN undefined, insert 3 patterns. Require PAT_COUNT=0 while DONE pulses 3 times.
